// File: rtl/cv32e41p_idx_to_mask.sv
// ============================================================================
// Module   : cv32e41p_idx_to_mask
// Brief    : Rebuilds a LEN-bit mask from a packetised stream of bit indices.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e41p_idx_to_mask #(
  parameter  int LEN = 32,
  localparam int IW  = $clog2(LEN),
  localparam int CW  = $clog2(LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          idx_valid_i,
  output logic          idx_ready_o,
  input  logic [IW-1:0] idx_i,
  input  logic          idx_last_i,
  output logic          mask_valid_o,
  input  logic          mask_ready_i,
  output logic [LEN-1:0] mask_o,
  output logic [CW-1:0] count_o,
  output logic          dup_o,
  output logic          oor_o
);

  localparam logic [LEN-1:0] c_one = {{(LEN-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_OUTPUT  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [LEN-1:0] r_mask;
  logic [CW-1:0]  r_count;
  logic           r_dup;
  logic           r_oor;

  logic           w_accept;
  logic           w_release;
  logic [LEN-1:0] w_onehot;
  logic           w_in_range;
  logic           w_bit_set;

  // Shifting past the top bit yields zero, so an empty one-hot marks an
  // out-of-range index without a separate magnitude compare.
  assign w_onehot   = c_one << idx_i;
  assign w_in_range = |w_onehot;
  assign w_bit_set  = |(r_mask & w_onehot);

  assign w_accept   = idx_valid_i & idx_ready_o;
  assign w_release  = mask_valid_o & mask_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    idx_ready_o  = 1'b0;
    mask_valid_o = 1'b0;
    case (r_state)
      S_COLLECT: begin
        idx_ready_o = 1'b1;
        if (idx_valid_i && idx_last_i) begin
          w_state_next = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        mask_valid_o = 1'b1;
        if (mask_ready_i) begin
          w_state_next = S_COLLECT;
        end
      end
      default: w_state_next = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_release) begin
      r_mask  <= '0;
      r_count <= '0;
      r_dup   <= 1'b0;
      r_oor   <= 1'b0;
    end else if (w_accept) begin
      if (!w_in_range) begin
        r_oor <= 1'b1;
      end else if (w_bit_set) begin
        r_dup <= 1'b1;
      end else begin
        r_mask  <= r_mask | w_onehot;
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign mask_o  = r_mask;
  assign count_o = r_count;
  assign dup_o   = r_dup;
  assign oor_o   = r_oor;

endmodule

`default_nettype wire

// File: tb/tb_cv32e41p_idx_to_mask.sv
// ============================================================================
// Module   : tb_cv32e41p_idx_to_mask
// Brief    : Directed self-checking bench for LEN=32 and LEN=20 instances.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e41p_idx_to_mask;

  logic clk;
  logic rst;

  // LEN = 32 instance
  logic        a_idx_valid, a_idx_ready, a_idx_last;
  logic [4:0]  a_idx;
  logic        a_mask_valid, a_mask_ready;
  logic [31:0] a_mask;
  logic [5:0]  a_count;
  logic        a_dup, a_oor;

  // LEN = 20 instance
  logic        b_idx_valid, b_idx_ready, b_idx_last;
  logic [4:0]  b_idx;
  logic        b_mask_valid, b_mask_ready;
  logic [19:0] b_mask;
  logic [4:0]  b_count;
  logic        b_dup, b_oor;

  int checks = 0;
  int errors = 0;

  cv32e41p_idx_to_mask #(.LEN(32)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .idx_valid_i  (a_idx_valid),
    .idx_ready_o  (a_idx_ready),
    .idx_i        (a_idx),
    .idx_last_i   (a_idx_last),
    .mask_valid_o (a_mask_valid),
    .mask_ready_i (a_mask_ready),
    .mask_o       (a_mask),
    .count_o      (a_count),
    .dup_o        (a_dup),
    .oor_o        (a_oor)
  );

  cv32e41p_idx_to_mask #(.LEN(20)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .idx_valid_i  (b_idx_valid),
    .idx_ready_o  (b_idx_ready),
    .idx_i        (b_idx),
    .idx_last_i   (b_idx_last),
    .mask_valid_o (b_mask_valid),
    .mask_ready_i (b_mask_ready),
    .mask_o       (b_mask),
    .count_o      (b_count),
    .dup_o        (b_dup),
    .oor_o        (b_oor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input int idx, input bit last);
    a_idx_valid = 1'b1;
    a_idx       = idx[4:0];
    a_idx_last  = last;
    step();
    a_idx_valid = 1'b0;
    a_idx       = 'x;
    a_idx_last  = 'x;
  endtask

  task automatic beat_b(input int idx, input bit last);
    b_idx_valid = 1'b1;
    b_idx       = idx[4:0];
    b_idx_last  = last;
    step();
    b_idx_valid = 1'b0;
    b_idx       = 'x;
    b_idx_last  = 'x;
  endtask

  task automatic pop_a();
    a_mask_ready = 1'b1;
    step();
    a_mask_ready = 1'b0;
  endtask

  task automatic pop_b();
    b_mask_ready = 1'b1;
    step();
    b_mask_ready = 1'b0;
  endtask

  initial begin
    a_idx_valid = 1'b0; a_idx = '0; a_idx_last = 1'b0; a_mask_ready = 1'b0;
    b_idx_valid = 1'b0; b_idx = '0; b_idx_last = 1'b0; b_mask_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_ready",  {63'd0, a_idx_ready}, 64'd1);
    check("rst_valid",  {63'd0, a_mask_valid}, 64'd0);
    check("rst_mask",   {32'd0, a_mask}, 64'd0);
    check("rst_count",  {58'd0, a_count}, 64'd0);
    check("rst_flags",  {62'd0, a_dup, a_oor}, 64'd0);

    // 3,0,31(last)
    beat_a(3, 1'b0);
    check("p1_no_valid_mid", {63'd0, a_mask_valid}, 64'd0);
    beat_a(0, 1'b0);
    beat_a(31, 1'b1);
    check("p1_valid", {63'd0, a_mask_valid}, 64'd1);
    check("p1_mask",  {32'd0, a_mask}, 64'h8000_0009);
    check("p1_count", {58'd0, a_count}, 64'd3);
    check("p1_dup",   {63'd0, a_dup}, 64'd0);
    check("p1_ready_low", {63'd0, a_idx_ready}, 64'd0);
    pop_a();
    check("p1_released", {63'd0, a_mask_valid}, 64'd0);
    check("p1_cleared",  {32'd0, a_mask}, 64'd0);

    // 5,5,5(last) then hold with ready low while offering a beat
    beat_a(5, 1'b0);
    beat_a(5, 1'b0);
    beat_a(5, 1'b1);
    a_idx_valid = 1'b1; a_idx = 5'd9; a_idx_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("p2_hold_valid", {63'd0, a_mask_valid}, 64'd1);
      check("p2_hold_mask",  {32'd0, a_mask}, 64'h20);
      check("p2_hold_count", {58'd0, a_count}, 64'd1);
      check("p2_hold_dup",   {63'd0, a_dup}, 64'd1);
      check("p2_hold_ready", {63'd0, a_idx_ready}, 64'd0);
      step();
    end
    a_idx_valid = 1'b0;
    pop_a();
    check("p2_cleared_dup", {63'd0, a_dup}, 64'd0);

    // LEN=20: 19,25(last) then 2(last)
    beat_b(19, 1'b0);
    beat_b(25, 1'b1);
    check("b1_valid", {63'd0, b_mask_valid}, 64'd1);
    check("b1_mask",  {44'd0, b_mask}, 64'h80000);
    check("b1_count", {59'd0, b_count}, 64'd1);
    check("b1_oor",   {63'd0, b_oor}, 64'd1);
    check("b1_dup",   {63'd0, b_dup}, 64'd0);
    pop_b();
    beat_b(2, 1'b1);
    check("b2_mask",  {44'd0, b_mask}, 64'h4);
    check("b2_flags", {62'd0, b_dup, b_oor}, 64'd0);
    check("b2_count", {59'd0, b_count}, 64'd1);
    pop_b();
    // Packet of only out-of-range indices
    beat_b(20, 1'b0);
    beat_b(31, 1'b1);
    check("b3_mask",  {44'd0, b_mask}, 64'd0);
    check("b3_count", {59'd0, b_count}, 64'd0);
    check("b3_oor",   {63'd0, b_oor}, 64'd1);
    pop_b();

    // Back-to-back with mask_ready held high
    a_mask_ready = 1'b1;
    beat_a(1, 1'b1);
    check("bb1_valid", {63'd0, a_mask_valid}, 64'd1);
    check("bb1_mask",  {32'd0, a_mask}, 64'h2);
    check("bb1_idle",  {63'd0, a_idx_ready}, 64'd0);
    step();
    check("bb1_ready_back", {63'd0, a_idx_ready}, 64'd1);
    beat_a(2, 1'b1);
    check("bb2_mask",  {32'd0, a_mask}, 64'h4);
    check("bb2_count", {58'd0, a_count}, 64'd1);
    step();
    a_mask_ready = 1'b0;

    // Full mask plus a duplicate
    for (int i = 0; i < 32; i++) beat_a(i, 1'b0);
    check("full_partial_count", {58'd0, a_count}, 64'd32);
    beat_a(7, 1'b1);
    check("full_valid", {63'd0, a_mask_valid}, 64'd1);
    check("full_mask",  {32'd0, a_mask}, 64'hFFFF_FFFF);
    check("full_count", {58'd0, a_count}, 64'd32);
    check("full_dup",   {63'd0, a_dup}, 64'd1);
    pop_a();

    // Reset mid-packet
    beat_a(4, 1'b0);
    beat_a(6, 1'b0);
    check("mid_partial", {32'd0, a_mask}, 64'h50);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", {63'd0, a_mask_valid}, 64'd0);
    check("mid_rst_mask",  {32'd0, a_mask}, 64'd0);
    step();
    check("mid_rst_still_idle", {63'd0, a_mask_valid}, 64'd0);
    beat_a(9, 1'b1);
    check("post_rst_mask",  {32'd0, a_mask}, 64'h200);
    check("post_rst_count", {58'd0, a_count}, 64'd1);
    pop_a();

    // Reset while a mask is pending
    beat_a(12, 1'b1);
    check("pend_valid", {63'd0, a_mask_valid}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("pend_dropped", {63'd0, a_mask_valid}, 64'd0);
    check("pend_ready",   {63'd0, a_idx_ready}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
